// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle MIPS-subset control path:
// state encoding, opcode/funct values, ALU ops and PC source selects.
package ctrl_pkg;

  localparam int ALU_OP_W = 4;
  localparam int STATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    WB_R   = 4'd3,
    EXEC_I = 4'd4,
    WB_I   = 4'd5,
    ADDR   = 4'd6,
    MEM_RD = 4'd7,
    MEM_WR = 4'd8,
    WB_MEM = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_NOP = 6'b000000;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'b1010;

  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;

  // NOP (R-type, funct 0) retires straight from DECODE back to FETCH.
  function automatic state_t decode_next(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    state_t s;
    s = TRAP;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADD || fn == FN_SUB) s = EXEC_R;
        else if (fn == FN_NOP)            s = FETCH;
        else                              s = TRAP;
      end
      OP_ORI, OP_LUI: s = EXEC_I;
      OP_LW, OP_SW:   s = ADDR;
      OP_BEQ:         s = BRANCH;
      OP_J:           s = JUMP;
      default:        s = TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified instruction/data memory request/ready handshake.
// The controller drives requests; memory answers with mem_ready.
interface multicycle_ctrl_if;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/alu_op_decode.sv
// ALU operation select from state, opcode and funct.
// Shared with the single-cycle control path.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  state_t              i_state,
  input  logic [5:0]          i_opcode,
  input  logic [5:0]          i_funct,
  output logic [ALU_OP_W-1:0] o_alu_op
);

  always_comb begin
    o_alu_op = ALU_ADD;
    unique case (1'b1)
      (i_state == EXEC_R || i_state == WB_R):
        o_alu_op = (i_funct == FN_SUB) ? ALU_SUB : ALU_ADD;
      (i_state == EXEC_I || i_state == WB_I):
        o_alu_op = (i_opcode == OP_LUI) ? ALU_LUI : ALU_OR;
      (i_state == BRANCH):
        o_alu_op = ALU_SUB;
      default: o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: time-shares one ALU and one memory port
// across fetch/decode/execute/memory/writeback; traps on bad encodings.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   mem,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                retire,
  output logic                illegal,
  output logic [STATE_W-1:0]  dbg_state
);

  state_t              r_state;
  state_t              w_next;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_iord;

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  alu_op_decode u_alu_dec (
    .i_state  (r_state),
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_alu_op (w_alu_op)
  );

  always_comb begin
    w_next      = r_state;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_iord      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_INC;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src     = 1'b0;
    alu_op      = w_alu_op;
    retire      = 1'b0;
    illegal     = 1'b0;
    dbg_state   = r_state;
    unique case (r_state)
      FETCH: begin
        w_mem_read = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = DECODE;
        end
      end
      DECODE: begin
        w_next = decode_next(opcode, funct);
        retire = (opcode == OP_RTYPE) && (funct == FN_NOP);
      end
      EXEC_R: w_next = WB_R;
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        w_next    = FETCH;
      end
      EXEC_I: begin
        alu_src = 1'b1;
        w_next  = WB_I;
      end
      WB_I: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        retire    = 1'b1;
        w_next    = FETCH;
      end
      ADDR: begin
        alu_src = 1'b1;
        w_next  = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (mem.mem_ready) w_next = WB_MEM;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        w_next     = FETCH;
      end
      MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (mem.mem_ready) begin
          retire = 1'b1;
          w_next = FETCH;
        end
      end
      BRANCH: begin
        pc_src   = PC_SRC_BR;
        pc_write = zero;
        retire   = 1'b1;
        w_next   = FETCH;
      end
      JUMP: begin
        pc_src   = PC_SRC_JMP;
        pc_write = 1'b1;
        retire   = 1'b1;
        w_next   = FETCH;
      end
      TRAP: illegal = 1'b1;
      default: w_next = TRAP;
    endcase
    // Reset overrides everything, abandoning any outstanding access.
    if (rst) begin
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_iord      = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src     = 1'b0;
      alu_op      = '0;
      retire      = 1'b0;
      illegal     = 1'b0;
      dbg_state   = '0;
    end
  end

  assign mem.mem_read  = w_mem_read;
  assign mem.mem_write = w_mem_write;
  assign mem.iord      = w_iord;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle-slot model,
// directed latency pins plus randomized instruction/stall stream.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mrd;
    logic       mwr;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rgw;
    logic       rdst;
    logic       m2r;
    logic       asrc;
    logic [3:0] aop;
    logic       ret;
    logic       ill;
  } ov_t;

  localparam int C_ADD = 0;
  localparam int C_SUB = 1;
  localparam int C_NOP = 2;
  localparam int C_ORI = 3;
  localparam int C_LUI = 4;
  localparam int C_LW  = 5;
  localparam int C_SW  = 6;
  localparam int C_BEQ = 7;
  localparam int C_J   = 8;
  localparam int C_ILL = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       ir_write, pc_write, reg_write, reg_dst;
  logic       mem_to_reg, alu_src, retire, illegal;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic [3:0] dbg_state;

  multicycle_ctrl_if u_if ();
  assign u_if.mem_ready = mem_ready;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (u_if.master),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .retire     (retire),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cls = C_NOP;
  int   slot = 0;
  logic chk_en = 1'b0;
  logic exp_rst = 1'b0;
  ov_t  exp_o;

  function automatic int ilen(input int c);
    case (c)
      C_NOP:      return 2;
      C_BEQ, C_J: return 3;
      C_LW:       return 5;
      C_ILL:      return 100000;
      default:    return 4;
    endcase
  endfunction

  function automatic logic is_wait(input int c, input int s);
    return (s == 0) || ((c == C_LW || c == C_SW) && s == 3);
  endfunction

  // Expected outputs for cycle s of an instruction of class c.
  function automatic ov_t model_out(
    input int c, input int s, input logic mr, input logic z
  );
    ov_t o;
    o = '0;
    if (s == 0) begin
      o.mrd = 1'b1;
      o.irw = mr;
      o.pcw = mr;
      return o;
    end
    if (s == 1) begin
      o.ret = (c == C_NOP);
      return o;
    end
    case (c)
      C_ADD, C_SUB: begin
        o.aop = (c == C_SUB) ? 4'b0001 : 4'b0000;
        if (s == 3) begin
          o.rgw = 1'b1; o.rdst = 1'b1; o.ret = 1'b1;
        end
      end
      C_ORI, C_LUI: begin
        o.asrc = 1'b1;
        o.aop = (c == C_LUI) ? 4'b1010 : 4'b1001;
        if (s == 3) begin
          o.rgw = 1'b1; o.ret = 1'b1;
        end
      end
      C_LW: begin
        if (s == 2) o.asrc = 1'b1;
        if (s == 3) begin o.mrd = 1'b1; o.iord = 1'b1; end
        if (s == 4) begin
          o.rgw = 1'b1; o.m2r = 1'b1; o.ret = 1'b1;
        end
      end
      C_SW: begin
        if (s == 2) o.asrc = 1'b1;
        if (s == 3) begin
          o.mwr = 1'b1; o.iord = 1'b1; o.ret = mr;
        end
      end
      C_BEQ: begin
        o.aop = 4'b0001; o.pcs = 2'b01; o.pcw = z; o.ret = 1'b1;
      end
      C_J: begin
        o.pcs = 2'b10; o.pcw = 1'b1; o.ret = 1'b1;
      end
      default: o.ill = 1'b1;
    endcase
    return o;
  endfunction

  task automatic set_ir(input int c);
    int k;
    funct = 6'($urandom);
    opcode = 6'b000000;
    case (c)
      C_ADD: funct = 6'b100000;
      C_SUB: funct = 6'b100010;
      C_NOP: funct = 6'b000000;
      C_ORI: opcode = 6'b001101;
      C_LUI: opcode = 6'b001111;
      C_LW:  opcode = 6'b100011;
      C_SW:  opcode = 6'b101011;
      C_BEQ: opcode = 6'b000100;
      C_J:   opcode = 6'b000010;
      default: begin
        k = $urandom_range(0, 2);
        if (k == 0) opcode = 6'b111111;
        else if (k == 1) opcode = 6'b000011;
        else funct = 6'b000001;
      end
    endcase
  endtask

  task automatic cyc(
    input logic r, input logic mr, input logic z, output logic ret
  );
    rst = r;
    mem_ready = mr;
    zero = z;
    exp_rst = r;
    exp_o = r ? '0 : model_out(cls, slot, mr, z);
    chk_en = 1'b1;
    @(negedge clk);
    ret = retire;
    @(posedge clk);
    if (r) slot = 0;
    else if (!(is_wait(cls, slot) && !mr)) slot++;
    #1;
  endtask

  task automatic run_instr(
    input int c, input int fst, input int mst, input logic z,
    input int lim, output int lat
  );
    int   n;
    int   fs;
    int   ms;
    logic mr;
    logic ret;
    cls = c;
    slot = 0;
    set_ir(c);
    lat = 0;
    n = 0;
    fs = fst;
    ms = mst;
    while (slot < ilen(c) && n < lim) begin
      if (slot == 0) begin
        mr = (fs > 0) ? 1'b0 : 1'b1;
        if (fs > 0) fs--;
      end else if (is_wait(c, slot)) begin
        mr = (ms > 0) ? 1'b0 : 1'b1;
        if (ms > 0) ms--;
      end else begin
        mr = 1'($urandom);
      end
      cyc(1'b0, mr, z, ret);
      n++;
      if (ret && lat == 0) lat = n;
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    ov_t act;
    if (chk_en) begin
      act.mrd  = u_if.mem_read;
      act.mwr  = u_if.mem_write;
      act.iord = u_if.iord;
      act.irw  = ir_write;
      act.pcw  = pc_write;
      act.pcs  = pc_src;
      act.rgw  = reg_write;
      act.rdst = reg_dst;
      act.m2r  = mem_to_reg;
      act.asrc = alu_src;
      act.aop  = alu_op;
      act.ret  = retire;
      act.ill  = illegal;
      n_vec++;
      if (act !== exp_o || (exp_rst && dbg_state !== 4'd0)) begin
        n_bad++;
        $display("FAIL outputs cls=%0d slot=%0d rst=%b: got %h dbg=%0d want %h",
                 cls, slot, exp_rst, act, dbg_state, exp_o);
      end
      n_vec++;
      if ((u_if.mem_read && u_if.mem_write) || (reg_write && pc_write)) begin
        n_bad++;
        $display("FAIL exclusive_strobes: got rd=%b wr=%b rw=%b pw=%b want no overlap",
                 u_if.mem_read, u_if.mem_write, reg_write, pc_write);
      end
    end
  end

  initial begin
    int   lat;
    int   c;
    logic ret;
    rst = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b0;
    opcode = '0;
    funct = '0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b1, 1'b0, ret);
    cyc(1'b1, 1'b1, 1'b0, ret);

    run_instr(C_ADD, 0, 0, 1'b0, 40, lat); chk("add_lat", lat, 4);
    run_instr(C_LW,  0, 3, 1'b0, 40, lat); chk("lw_stall_lat", lat, 8);
    run_instr(C_BEQ, 0, 0, 1'b1, 40, lat); chk("beq_taken_lat", lat, 3);
    run_instr(C_BEQ, 0, 0, 1'b0, 40, lat); chk("beq_not_lat", lat, 3);
    run_instr(C_ORI, 0, 0, 1'b0, 40, lat); chk("ori_lat", lat, 4);
    run_instr(C_LUI, 0, 0, 1'b0, 40, lat); chk("lui_lat", lat, 4);
    run_instr(C_SW,  0, 0, 1'b0, 40, lat); chk("sw_lat", lat, 4);
    run_instr(C_J,   0, 0, 1'b0, 40, lat); chk("j_lat", lat, 3);
    run_instr(C_NOP, 0, 0, 1'b0, 40, lat); chk("nop_lat", lat, 2);
    run_instr(C_SUB, 2, 0, 1'b0, 40, lat); chk("sub_fstall_lat", lat, 6);

    cls = C_ILL; slot = 0; set_ir(C_ILL); opcode = 6'b111111;
    begin
      int n;
      lat = 0;
      n = 0;
      while (n < 22) begin
        cyc(1'b0, 1'($urandom), 1'($urandom), ret);
        n++;
        if (ret && lat == 0) lat = n;
      end
    end
    chk("trap_no_retire", lat, 0);
    cyc(1'b1, 1'b0, 1'b0, ret);

    // Reset while a store is stalled waiting for mem_ready.
    cls = C_SW; slot = 0; set_ir(C_SW);
    while (slot < 3) cyc(1'b0, 1'b1, 1'b0, ret);
    cyc(1'b0, 1'b0, 1'b0, ret);
    cyc(1'b0, 1'b0, 1'b0, ret);
    cyc(1'b1, 1'b0, 1'b0, ret);
    run_instr(C_ADD, 0, 0, 1'b0, 40, lat); chk("restart_add_lat", lat, 4);

    for (int i = 0; i < 300; i++) begin
      c = $urandom_range(0, 9);
      if (c == C_ILL) begin
        run_instr(C_ILL, $urandom_range(0, 2), 0, 1'($urandom),
                  $urandom_range(3, 8), lat);
        cyc(1'b1, 1'($urandom), 1'b0, ret);
      end else begin
        run_instr(c, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                  1'($urandom), 40, lat);
      end
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
